// File: rtl/lcd_pkg.sv
// Shared constants and FSM encoding for the 2-line text-LCD buffer
// and the downstream LCD controller.
package lcd_pkg;

  localparam int          COLS   = 16;
  localparam int          CHAR_W = 8;
  localparam logic [7:0]  BLANK  = 8'h20;

  localparam logic [7:0]  ASCII_SPACE = 8'h20;
  localparam logic [7:0]  ASCII_DOT   = 8'h2E;
  localparam logic [7:0]  ASCII_ZERO  = 8'h30;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROT   = 2'd1,
    S_CLEAR = 2'd2
  } state_e;

endpackage

// File: rtl/lcd_char_ram.sv
// 2 x COLS character store: one write port, one registered read port.
// Reads return the pre-edge contents of the addressed cell.
module lcd_char_ram
  import lcd_pkg::*;
#(
  parameter int                 COLS   = lcd_pkg::COLS,
  parameter int                 CHAR_W = lcd_pkg::CHAR_W,
  parameter logic [CHAR_W-1:0]  BLANK  = lcd_pkg::BLANK,
  localparam int                CW     = $clog2(COLS)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              we_i,
  input  logic              wline_i,
  input  logic [CW-1:0]     wcol_i,
  input  logic [CHAR_W-1:0] wdata_i,
  input  logic              rline_i,
  input  logic [CW-1:0]     rcol_i,
  output logic [CHAR_W-1:0] rdata_o
);

  logic [CHAR_W-1:0] mem_q [2][COLS];
  logic [CHAR_W-1:0] rdata_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int l = 0; l < 2; l++) begin
        for (int c = 0; c < COLS; c++) begin
          mem_q[l][c] <= BLANK;
        end
      end
      rdata_q <= BLANK;
    end else begin
      if (we_i) begin
        mem_q[wline_i][wcol_i] <= wdata_i;
      end
      rdata_q <= mem_q[rline_i][rcol_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lcd_text_buffer.sv
// 2x16 LCD frame buffer with per-line marquee offsets, timed clear
// and a refresh-needed flag for the LCD controller.
module lcd_text_buffer
  import lcd_pkg::*;
#(
  parameter int                 COLS   = lcd_pkg::COLS,
  parameter int                 CHAR_W = lcd_pkg::CHAR_W,
  parameter logic [CHAR_W-1:0]  BLANK  = lcd_pkg::BLANK,
  localparam int                CW     = $clog2(COLS)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              wr_line,
  input  logic [CW-1:0]     wr_col,
  input  logic [CHAR_W-1:0] wr_char,
  input  logic              rot_req,
  input  logic              rot_dir,
  input  logic              rot_line,
  input  logic              clr_req,
  output logic              busy,
  input  logic              rd_line,
  input  logic [CW-1:0]     rd_col,
  output logic [CHAR_W-1:0] rd_char,
  output logic              dirty,
  input  logic              dirty_ack
);

  state_e            state_q;
  logic [CW-1:0]     off_q [2];
  logic [CW:0]       cnt_q;
  logic              rdir_q;
  logic              rline_q;
  logic              dirty_q;

  logic              wr_fire;
  logic              clr_done;
  logic              dirty_set;
  logic              ram_we;
  logic              ram_wline;
  logic [CW-1:0]     ram_wcol;
  logic [CHAR_W-1:0] ram_wdata;
  logic [CW-1:0]     rd_phys;

  assign wr_ready  = (state_q == S_IDLE) && !clr_req && !rot_req;
  assign wr_fire   = wr_valid && wr_ready;
  assign clr_done  = (state_q == S_CLEAR) && (cnt_q == '1);
  assign dirty_set = wr_fire || (state_q == S_ROT) || clr_done;
  assign rd_phys   = rd_col + off_q[rd_line];

  // Clear sweeps physical cells; counter MSB selects the line.
  always_comb begin
    ram_we    = 1'b0;
    ram_wline = wr_line;
    ram_wcol  = wr_col + off_q[wr_line];
    ram_wdata = wr_char;
    unique case (1'b1)
      (state_q == S_CLEAR): begin
        ram_we    = 1'b1;
        ram_wline = cnt_q[CW];
        ram_wcol  = cnt_q[CW-1:0];
        ram_wdata = BLANK;
      end
      wr_fire: ram_we = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      off_q[0] <= '0;
      off_q[1] <= '0;
      cnt_q    <= '0;
      rdir_q   <= 1'b0;
      rline_q  <= 1'b0;
      dirty_q  <= 1'b1;
    end else begin
      dirty_q <= dirty_set || (dirty_q && !dirty_ack);
      unique case (state_q)
        S_IDLE: begin
          if (clr_req) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
          end else if (rot_req) begin
            state_q <= S_ROT;
            rdir_q  <= rot_dir;
            rline_q <= rot_line;
          end
        end
        S_ROT: begin
          off_q[rline_q] <= rdir_q ? off_q[rline_q] - CW'(1)
                                   : off_q[rline_q] + CW'(1);
          state_q <= S_IDLE;
        end
        S_CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (clr_done) begin
            off_q[0] <= '0;
            off_q[1] <= '0;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign dirty = dirty_q;

  lcd_char_ram #(
    .COLS   (COLS),
    .CHAR_W (CHAR_W),
    .BLANK  (BLANK)
  ) u_ram (
    .clk     (clk),
    .resetn  (resetn),
    .we_i    (ram_we),
    .wline_i (ram_wline),
    .wcol_i  (ram_wcol),
    .wdata_i (ram_wdata),
    .rline_i (rd_line),
    .rcol_i  (rd_phys),
    .rdata_o (rd_char)
  );

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Directed bench for lcd_text_buffer: writes, marquee rotation,
// timed clear, reset during clear and dirty handshake.
module tb_lcd_text_buffer;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic       wr_line = 1'b0;
  logic [3:0] wr_col = '0;
  logic [7:0] wr_char = '0;
  logic       rot_req = 1'b0;
  logic       rot_dir = 1'b0;
  logic       rot_line = 1'b0;
  logic       clr_req = 1'b0;
  logic       busy;
  logic       rd_line = 1'b0;
  logic [3:0] rd_col = '0;
  logic [7:0] rd_char;
  logic       dirty;
  logic       dirty_ack = 1'b0;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  lcd_text_buffer dut (
    .clk       (clk),
    .resetn    (resetn),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_line   (wr_line),
    .wr_col    (wr_col),
    .wr_char   (wr_char),
    .rot_req   (rot_req),
    .rot_dir   (rot_dir),
    .rot_line  (rot_line),
    .clr_req   (clr_req),
    .busy      (busy),
    .rd_line   (rd_line),
    .rd_col    (rd_col),
    .rd_char   (rd_char),
    .dirty     (dirty),
    .dirty_ack (dirty_ack)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic l, input logic [3:0] c,
                    output logic [7:0] d);
    rd_line = l;
    rd_col  = c;
    tick();
    d = rd_char;
  endtask

  task automatic wr(input logic l, input logic [3:0] c,
                    input logic [7:0] ch);
    wr_valid = 1'b1;
    wr_line  = l;
    wr_col   = c;
    wr_char  = ch;
    check("wr_ready", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic rot(input logic dir, input logic l);
    rot_req  = 1'b1;
    rot_dir  = dir;
    rot_line = l;
    tick();
    rot_req = 1'b0;
    tick();
  endtask

  task automatic ack();
    dirty_ack = 1'b1;
    tick();
    dirty_ack = 1'b0;
  endtask

  logic [7:0] msg [8] = '{8'h52, 8'h6F, 8'h74, 8'h61,
                          8'h74, 8'h69, 8'h6E, 8'h67};

  initial begin
    logic [7:0] d;
    int n;
    int bad;

    repeat (2) tick();
    check("rst_rd", 32'(rd_char), 32'h20);
    check("rst_dirty", 32'(dirty), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    rd(1'b0, 4'd0, d);
    check("rd_0_0", 32'(d), 32'h20);
    rd(1'b1, 4'd15, d);
    check("rd_1_15", 32'(d), 32'h20);
    check("idle_ready", 32'(wr_ready), 32'd1);
    ack();
    check("ack_dirty", 32'(dirty), 32'd0);

    for (int i = 0; i < 8; i++) wr(1'b0, 4'(i), msg[i]);
    check("wr_dirty", 32'(dirty), 32'd1);
    rd(1'b0, 4'd1, d);
    check("rd_col1", 32'(d), 32'h6F);
    rd(1'b0, 4'd7, d);
    check("rd_col7", 32'(d), 32'h67);

    ack();
    rot_req  = 1'b1;
    rot_dir  = 1'b0;
    rot_line = 1'b0;
    tick();
    rot_req = 1'b0;
    check("rot_busy", 32'(busy), 32'd1);
    tick();
    check("rot_done", 32'(busy), 32'd0);
    check("rot_dirty", 32'(dirty), 32'd1);
    rd(1'b0, 4'd0, d);
    check("rotl_c0", 32'(d), 32'h6F);
    rd(1'b0, 4'd15, d);
    check("rotl_c15", 32'(d), 32'h52);
    rd(1'b1, 4'd0, d);
    check("rotl_l1", 32'(d), 32'h20);

    for (int i = 0; i < 15; i++) rot(1'b0, 1'b0);
    rd(1'b0, 4'd0, d);
    check("rot16_c0", 32'(d), 32'h52);

    rot(1'b1, 1'b0);
    rd(1'b0, 4'd0, d);
    check("rotr_c0", 32'(d), 32'h20);
    rd(1'b0, 4'd1, d);
    check("rotr_c1", 32'(d), 32'h52);

    ack();
    clr_req  = 1'b1;
    rot_req  = 1'b1;
    wr_valid = 1'b1;
    wr_line  = 1'b1;
    wr_col   = 4'd3;
    wr_char  = 8'h41;
    #1;
    check("prio_ready", 32'(wr_ready), 32'd0);
    tick();
    clr_req  = 1'b0;
    rot_req  = 1'b0;
    wr_valid = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check("clr_cycles", 32'(n), 32'd32);
    check("clr_dirty", 32'(dirty), 32'd1);
    bad = 0;
    for (int l = 0; l < 2; l++) begin
      for (int c = 0; c < 16; c++) begin
        rd(1'(l), 4'(c), d);
        if (d !== 8'h20) bad++;
      end
    end
    check("clr_cells", 32'(bad), 32'd0);

    rot(1'b0, 1'b1);
    wr(1'b1, 4'd2, 8'h58);
    rd(1'b1, 4'd2, d);
    check("pre_rst", 32'(d), 32'h58);
    ack();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    check("mid_clr_busy", 32'(busy), 32'd1);
    resetn = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_dirty", 32'(dirty), 32'd1);
    check("arst_rd", 32'(rd_char), 32'h20);
    tick();
    resetn = 1'b1;
    rd(1'b1, 4'd2, d);
    check("arst_cell", 32'(d), 32'h20);
    wr(1'b1, 4'd6, 8'h36);
    rd(1'b1, 4'd6, d);
    check("post_rst_wr", 32'(d), 32'h36);

    rd_line  = 1'b0;
    rd_col   = 4'd4;
    wr_valid = 1'b1;
    wr_line  = 1'b0;
    wr_col   = 4'd4;
    wr_char  = 8'h7A;
    tick();
    wr_valid = 1'b0;
    check("rbw_old", 32'(rd_char), 32'h20);
    tick();
    check("rbw_new", 32'(rd_char), 32'h7A);

    ack();
    check("ack2", 32'(dirty), 32'd0);
    dirty_ack = 1'b1;
    wr_valid  = 1'b1;
    wr_line   = 1'b0;
    wr_col    = 4'd9;
    wr_char   = 8'h41;
    tick();
    wr_valid = 1'b0;
    check("set_wins", 32'(dirty), 32'd1);
    tick();
    dirty_ack = 1'b0;
    check("ack_after", 32'(dirty), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
